// File: rtl/rv32i_mem_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
//   DMem_req/we/addr/wdata/be : request, held by the master until DMem_ack
//   DMem_ack                  : single-cycle completion pulse from memory
//   DMem_rdata                : read word, valid with DMem_ack
interface rv32i_mem_if;
  logic        DMem_req;
  logic        DMem_we;
  logic [31:0] DMem_addr;
  logic [31:0] DMem_wdata;
  logic [3:0]  DMem_be;
  logic        DMem_ack;
  logic [31:0] DMem_rdata;

  modport master (
    output DMem_req, DMem_we, DMem_addr, DMem_wdata, DMem_be,
    input  DMem_ack, DMem_rdata
  );

  modport slave (
    input  DMem_req, DMem_we, DMem_addr, DMem_wdata, DMem_be,
    output DMem_ack, DMem_rdata
  );
endinterface

// File: rtl/rv32i_mem.sv
// RV32I MEM stage: issues loads/stores on the data bus, formats load data
// and holds the MEM/WB register.
//   Clk, Reset_n          : clock, async active-low reset
//   EX_*                  : instruction arriving from EX
//   dmem (master)         : data-memory bus, registered request outputs
//   MEM_Stall             : freezes upstream stages while a bus access is open
//   MEM_RegFile_wr_en/Rd_addr/Rd_data : MEM/WB register
//   MEM_Misaligned        : one-cycle pulse on an illegal access
module rv32i_mem (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        EX_Mem_rd_en,
  input  logic        EX_Mem_wr_en,
  input  logic [2:0]  EX_Mem_op,
  input  logic        EX_MemToReg,
  input  logic [31:0] EX_ALU_result,
  input  logic [31:0] EX_Rs2_data,
  input  logic        EX_RegFile_wr_en,
  input  logic [4:0]  EX_Rd_addr,
  rv32i_mem_if.master dmem,
  output logic        MEM_Stall,
  output logic        MEM_RegFile_wr_en,
  output logic [4:0]  MEM_Rd_addr,
  output logic [31:0] MEM_Rd_data,
  output logic        MEM_Misaligned
);
  typedef enum logic {IDLE, REQ} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wen_q, wen_d, mis_q, mis_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  // access context latched at request time
  logic [2:0]  op_q, op_d;
  logic [31:0] alu_q, alu_d;
  logic        m2r_q, m2r_d, ld_q, ld_d, lwen_q, lwen_d;

  logic        access, is_load, illegal;
  logic [1:0]  off;
  logic [31:0] st_wdata, lane, fmt;
  logic [3:0]  st_be;

  assign access  = EX_Mem_rd_en | EX_Mem_wr_en;
  assign is_load = EX_Mem_rd_en;              // rd+wr together counts as a load
  assign off     = EX_ALU_result[1:0];

  always_comb begin
    illegal = 1'b1;
    case (EX_Mem_op)
      3'b000: illegal = 1'b0;
      3'b001: illegal = off[0];
      3'b010: illegal = (off != 2'b00);
      3'b100: illegal = !is_load;
      3'b101: illegal = off[0] | !is_load;
      default: illegal = 1'b1;
    endcase
  end

  // Same lane layout for loads and stores; wdata is only meaningful for stores.
  always_comb begin
    case (EX_Mem_op[1:0])
      2'b00: begin st_wdata = {4{EX_Rs2_data[7:0]}};  st_be = 4'b0001 << off; end
      2'b01: begin st_wdata = {2{EX_Rs2_data[15:0]}}; st_be = 4'b0011 << off; end
      default: begin st_wdata = EX_Rs2_data;          st_be = 4'b1111;        end
    endcase
  end

  assign lane = dmem.DMem_rdata >> {alu_q[1:0], 3'b000};

  always_comb begin
    case (op_q)
      3'b000:  fmt = {{24{lane[7]}}, lane[7:0]};
      3'b001:  fmt = {{16{lane[15]}}, lane[15:0]};
      3'b100:  fmt = {24'b0, lane[7:0]};
      3'b101:  fmt = {16'b0, lane[15:0]};
      default: fmt = dmem.DMem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;   we_d    = we_q;
    addr_d  = addr_q;  wdata_d = wdata_q;  be_d = be_q;
    wen_d   = wen_q;   rd_d    = rd_q;     data_d = data_q;
    mis_d   = 1'b0;
    op_d    = op_q;    alu_d   = alu_q;
    m2r_d   = m2r_q;   ld_d    = ld_q;     lwen_d = lwen_q;
    case (state_q)
      IDLE: begin
        if (!access) begin
          wen_d  = EX_RegFile_wr_en;
          rd_d   = EX_Rd_addr;
          data_d = EX_ALU_result;
        end else if (illegal) begin
          mis_d = 1'b1;
          wen_d = 1'b0;
        end else begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = !is_load;
          addr_d  = {EX_ALU_result[31:2], 2'b00};
          wdata_d = st_wdata;
          be_d    = st_be;
          wen_d   = 1'b0;
          rd_d    = EX_Rd_addr;
          op_d    = EX_Mem_op;
          alu_d   = EX_ALU_result;
          m2r_d   = EX_MemToReg;
          ld_d    = is_load;
          lwen_d  = EX_RegFile_wr_en;
        end
      end
      REQ: begin
        wen_d = 1'b0;
        if (dmem.DMem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          data_d  = m2r_q ? fmt : alu_q;
          wen_d   = ld_q & lwen_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      req_q <= 1'b0;  we_q <= 1'b0;  addr_q <= '0;  wdata_q <= '0;  be_q <= '0;
      wen_q <= 1'b0;  rd_q <= '0;    data_q <= '0;  mis_q <= 1'b0;
      op_q  <= '0;    alu_q <= '0;   m2r_q <= 1'b0; ld_q <= 1'b0;   lwen_q <= 1'b0;
    end else begin
      req_q <= req_d;  we_q <= we_d;  addr_q <= addr_d;  wdata_q <= wdata_d;  be_q <= be_d;
      wen_q <= wen_d;  rd_q <= rd_d;  data_q <= data_d;  mis_q <= mis_d;
      op_q  <= op_d;   alu_q <= alu_d; m2r_q <= m2r_d;   ld_q <= ld_d;        lwen_q <= lwen_d;
    end
  end

  assign dmem.DMem_req   = req_q;
  assign dmem.DMem_we    = we_q;
  assign dmem.DMem_addr  = addr_q;
  assign dmem.DMem_wdata = wdata_q;
  assign dmem.DMem_be    = be_q;

  assign MEM_Stall         = (state_q == REQ);
  assign MEM_RegFile_wr_en = wen_q;
  assign MEM_Rd_addr       = rd_q;
  assign MEM_Rd_data       = data_q;
  assign MEM_Misaligned    = mis_q;
endmodule

// File: tb/tb_rv32i_mem.sv
// Bench for rv32i_mem: directed cases followed by random instructions checked
// against a transaction-level reference model.
module tb_rv32i_mem;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        EX_Mem_rd_en, EX_Mem_wr_en, EX_MemToReg, EX_RegFile_wr_en;
  logic [2:0]  EX_Mem_op;
  logic [31:0] EX_ALU_result, EX_Rs2_data;
  logic [4:0]  EX_Rd_addr;
  logic        MEM_Stall, MEM_RegFile_wr_en, MEM_Misaligned;
  logic [4:0]  MEM_Rd_addr;
  logic [31:0] MEM_Rd_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  rv32i_mem_if dmem();

  rv32i_mem dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .EX_Mem_rd_en(EX_Mem_rd_en), .EX_Mem_wr_en(EX_Mem_wr_en),
    .EX_Mem_op(EX_Mem_op), .EX_MemToReg(EX_MemToReg),
    .EX_ALU_result(EX_ALU_result), .EX_Rs2_data(EX_Rs2_data),
    .EX_RegFile_wr_en(EX_RegFile_wr_en), .EX_Rd_addr(EX_Rd_addr),
    .dmem(dmem.master),
    .MEM_Stall(MEM_Stall), .MEM_RegFile_wr_en(MEM_RegFile_wr_en),
    .MEM_Rd_addr(MEM_Rd_addr), .MEM_Rd_data(MEM_Rd_data),
    .MEM_Misaligned(MEM_Misaligned)
  );

  typedef struct {
    logic        rd, wr, m2r, wen;
    logic [2:0]  op;
    logic [31:0] alu, rs2;
    logic [4:0]  rda;
  } ins_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // ---- reference model -------------------------------------------------
  function automatic int nbytes(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd4) return 1;
    if (op == 3'd1 || op == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic m_illegal(input ins_t i);
    int a = int'(i.alu[1:0]);
    if (i.op == 3'd3 || i.op == 3'd6 || i.op == 3'd7) return 1'b1;
    if (!i.rd && (i.op == 3'd4 || i.op == 3'd5)) return 1'b1;
    if (nbytes(i.op) == 4 && a != 0) return 1'b1;
    if (nbytes(i.op) == 2 && (a % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input ins_t i);
    int n = nbytes(i.op);
    return 4'(((1 << n) - 1) << int'(i.alu[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input ins_t i);
    int n = nbytes(i.op);
    logic [31:0] b = i.rs2 & 32'hFF;
    logic [31:0] h = i.rs2 & 32'hFFFF;
    if (n == 1) return b * 32'h01010101;
    if (n == 2) return h * 32'h00010001;
    return i.rs2;
  endfunction

  function automatic logic [31:0] m_load(input ins_t i, input logic [31:0] rdata);
    logic [31:0] w = rdata >> (8 * int'(i.alu[1:0]));
    case (i.op)
      3'd0: begin w = w & 32'hFF;   if (w > 32'd127)   w = w - 32'd256;   end
      3'd4: w = w & 32'hFF;
      3'd1: begin w = w & 32'hFFFF; if (w > 32'd32767) w = w - 32'd65536; end
      3'd5: w = w & 32'hFFFF;
      default: w = rdata;
    endcase
    return w;
  endfunction

  // ---- stimulus ----------------------------------------------------------
  task automatic drive(input ins_t i);
    EX_Mem_rd_en = i.rd;  EX_Mem_wr_en = i.wr;  EX_Mem_op = i.op;
    EX_MemToReg = i.m2r;  EX_ALU_result = i.alu; EX_Rs2_data = i.rs2;
    EX_RegFile_wr_en = i.wen; EX_Rd_addr = i.rda;
  endtask

  function automatic ins_t rnd_ins();
    ins_t i;
    logic [2:0] ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    i.alu = $urandom;  i.rs2 = $urandom;
    i.wen = 1'($urandom_range(0, 1));  i.m2r = 1'($urandom_range(0, 1));
    i.rda = 5'($urandom_range(0, 31));
    i.rd = 1'b0; i.wr = 1'b0;
    i.op = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 9) >= 4) begin
      case ($urandom_range(0, 2))
        0: i.rd = 1'b1;
        1: i.wr = 1'b1;
        default: begin i.rd = 1'b1; i.wr = 1'b1; end
      endcase
      if ($urandom_range(0, 7) != 0) i.op = ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) != 0) begin
        if (nbytes(i.op) == 4) i.alu[1:0] = 2'b00;
        if (nbytes(i.op) == 2) i.alu[0] = 1'b0;
      end
    end
    return i;
  endfunction

  // One instruction from EX through MEM; lat = wait cycles before ack,
  // stray = pulse ack while still IDLE (must be ignored).
  task automatic do_instr(input ins_t i, input int lat, input logic [31:0] rdata, input logic stray);
    int scnt;
    logic [31:0] exp_d;
    drive(i);
    dmem.DMem_ack = stray;
    dmem.DMem_rdata = $urandom;
    chk("stall_idle", 32'(MEM_Stall), 32'd0);
    step();
    dmem.DMem_ack = 1'b0;
    if (!(i.rd | i.wr)) begin
      chk("alu_wen",  32'(MEM_RegFile_wr_en), 32'(i.wen));
      chk("alu_rd",   32'(MEM_Rd_addr), 32'(i.rda));
      chk("alu_data", MEM_Rd_data, i.alu);
      chk("alu_mis",  32'(MEM_Misaligned), 32'd0);
      chk("alu_req",  32'(dmem.DMem_req), 32'd0);
      chk("alu_stall", 32'(MEM_Stall), 32'd0);
    end else if (m_illegal(i)) begin
      chk("bad_mis",   32'(MEM_Misaligned), 32'd1);
      chk("bad_wen",   32'(MEM_RegFile_wr_en), 32'd0);
      chk("bad_req",   32'(dmem.DMem_req), 32'd0);
      chk("bad_stall", 32'(MEM_Stall), 32'd0);
    end else begin
      chk("acc_mis",  32'(MEM_Misaligned), 32'd0);
      chk("acc_we",   32'(dmem.DMem_we), 32'(!i.rd));
      chk("acc_be",   32'(dmem.DMem_be), 32'(m_be(i)));
      if (!i.rd) chk("acc_wdata", dmem.DMem_wdata, m_wdata(i));
      drive(rnd_ins());          // EX content during REQ must be ignored
      scnt = 0;
      for (int k = 0; k <= lat; k++) begin
        if (k == lat) begin
          dmem.DMem_ack = 1'b1;
          dmem.DMem_rdata = rdata;
        end
        chk("req_hold",  32'(dmem.DMem_req), 32'd1);
        chk("addr_hold", dmem.DMem_addr, i.alu & 32'hFFFF_FFFC);
        chk("wen_req",   32'(MEM_RegFile_wr_en), 32'd0);
        if (MEM_Stall) scnt++;
        step();
      end
      dmem.DMem_ack = 1'b0;
      exp_d = i.m2r ? m_load(i, rdata) : i.alu;
      chk("stall_cycles", 32'(scnt), 32'(lat + 1));
      chk("done_stall", 32'(MEM_Stall), 32'd0);
      chk("done_req",   32'(dmem.DMem_req), 32'd0);
      chk("done_wen",   32'(MEM_RegFile_wr_en), 32'(i.rd & i.wen));
      chk("done_rd",    32'(MEM_Rd_addr), 32'(i.rda));
      chk("done_data",  MEM_Rd_data, exp_d);
    end
  endtask

  function automatic ins_t mk(input logic rd, input logic wr, input logic [2:0] op, input logic m2r,
                              input logic [31:0] alu, input logic [31:0] rs2, input logic wen,
                              input logic [4:0] rda);
    ins_t i;
    i.rd = rd; i.wr = wr; i.op = op; i.m2r = m2r; i.alu = alu; i.rs2 = rs2; i.wen = wen; i.rda = rda;
    return i;
  endfunction

  initial begin
    Reset_n = 1'b0;
    drive(mk(0, 0, 3'd0, 0, 32'h0, 32'h0, 0, 5'd0));
    dmem.DMem_ack = 1'b0;
    dmem.DMem_rdata = '0;
    #1;
    chk("rst_req",   32'(dmem.DMem_req), 32'd0);
    chk("rst_we",    32'(dmem.DMem_we), 32'd0);
    chk("rst_addr",  dmem.DMem_addr, 32'd0);
    chk("rst_be",    32'(dmem.DMem_be), 32'd0);
    chk("rst_stall", 32'(MEM_Stall), 32'd0);
    chk("rst_wen",   32'(MEM_RegFile_wr_en), 32'd0);
    chk("rst_data",  MEM_Rd_data, 32'd0);
    chk("rst_mis",   32'(MEM_Misaligned), 32'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    step();

    // directed cases
    do_instr(mk(0, 0, 3'd0, 0, 32'h1234, 32'h0, 1, 5'd5), 0, 32'h0, 1'b0);            // ADD
    do_instr(mk(0, 1, 3'd0, 0, 32'h103, 32'hAABBCCDD, 1, 5'd7), 2, 32'h0, 1'b0);      // SB
    do_instr(mk(1, 0, 3'd0, 1, 32'h202, 32'h0, 1, 5'd9), 3, 32'h12F45678, 1'b0);      // LB
    do_instr(mk(1, 0, 3'd4, 1, 32'h202, 32'h0, 1, 5'd9), 3, 32'h12F45678, 1'b0);      // LBU
    do_instr(mk(1, 0, 3'd2, 1, 32'h106, 32'h0, 1, 5'd3), 0, 32'h0, 1'b0);             // LW misaligned
    do_instr(mk(1, 0, 3'd2, 1, 32'h400, 32'h0, 1, 5'd4), 0, 32'hCAFEF00D, 1'b0);      // LW
    do_instr(mk(0, 0, 3'd0, 0, 32'h55, 32'h0, 1, 5'd6), 0, 32'h0, 1'b0);              // ADD after LW

    // reset mid-REQ
    drive(mk(1, 0, 3'd2, 1, 32'h300, 32'h0, 1, 5'd8));
    step();
    chk("mid_req_up", 32'(dmem.DMem_req), 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_req",   32'(dmem.DMem_req), 32'd0);
    chk("mid_rst_stall", 32'(MEM_Stall), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    drive(mk(0, 0, 3'd0, 0, 32'h77, 32'h0, 0, 5'd1));
    dmem.DMem_ack = 1'b1;
    dmem.DMem_rdata = 32'hDEADBEEF;
    step();
    dmem.DMem_ack = 1'b0;
    chk("late_ack_wen",   32'(MEM_RegFile_wr_en), 32'd0);
    chk("late_ack_stall", 32'(MEM_Stall), 32'd0);
    chk("late_ack_data",  MEM_Rd_data, 32'h77);

    // random traffic
    for (int n = 0; n < 400; n++)
      do_instr(rnd_ins(), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 3) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
